// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared types and sizes for the data-memory arbiter
package dmem_arbiter_pkg;
    localparam int DMEM_SIZE  = 1024;
    localparam int DMEM_BYTES = DMEM_SIZE * 4;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } dmem_arb_state_e;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's request/response channel into the arbiter
interface dmem_arbiter_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_align_check.sv
// dmem_align_check: flags illegal size, misaligned half/word or out-of-range address
module dmem_align_check #(
    parameter int unsigned DMEM_BYTES = dmem_arbiter_pkg::DMEM_BYTES
) (
    input  logic [1:0]  i_size,
    input  logic [31:0] i_addr,
    output logic        o_err
);
    import dmem_arbiter_pkg::*;

    assign o_err = (i_size == 2'b11)
                 | ((i_size == MEM_HALF) & i_addr[0])
                 | ((i_size == MEM_WORD) & (|i_addr[1:0]))
                 | (i_addr >= DMEM_BYTES);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter sequencing single-cycle accesses to the data memory
module dmem_arbiter #(
    parameter int unsigned DMEM_BYTES = dmem_arbiter_pkg::DMEM_BYTES,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave m0,
    dmem_arbiter_if.slave m1,
    output logic          mem_read,
    output logic          mem_write,
    output logic [1:0]    mem_size,
    output logic          unsigned_load,
    output logic [31:0]   data_addr,
    output logic [31:0]   data_write_data,
    input  logic [31:0]   data_read_data
);
    import dmem_arbiter_pkg::*;

    dmem_arb_state_e r_state;
    logic            r_last;
    logic            r_port;
    logic            r_we;
    logic            r_uns;
    logic            r_err;
    logic [1:0]      r_size;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;

    logic            w_open;
    logic            w_grant;
    logic            w_accept;
    logic            w_err;
    logic            w_drive;
    logic            w_rsp0;
    logic            w_rsp1;
    logic [1:0]      w_size;
    logic [31:0]     w_addr;

    // A new request can be taken whenever the memory bus is not busy
    assign w_open   = r_state != ACCESS;
    assign w_grant  = (m0.req_valid & m1.req_valid) ? ((FIXED_PRIO != 0) ? 1'b0 : ~r_last)
                                                    : m1.req_valid;
    assign w_accept = w_open & (m0.req_valid | m1.req_valid);

    assign m0.req_ready = w_open & m0.req_valid & ~w_grant;
    assign m1.req_ready = w_open & m1.req_valid & w_grant;

    assign w_size = w_grant ? m1.req_size : m0.req_size;
    assign w_addr = w_grant ? m1.req_addr : m0.req_addr;

    dmem_align_check #(.DMEM_BYTES(DMEM_BYTES)) u_align (
        .i_size (w_size),
        .i_addr (w_addr),
        .o_err  (w_err)
    );

    // Sequencer: latch the winning request, run one memory cycle, then present the response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_err   <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= (r_state == ACCESS) ? RESP : (w_accept ? ACCESS : IDLE);
            if (w_accept) begin
                r_last  <= w_grant;
                r_port  <= w_grant;
                r_we    <= w_grant ? m1.req_we : m0.req_we;
                r_uns   <= w_grant ? m1.req_unsigned : m0.req_unsigned;
                r_wdata <= w_grant ? m1.req_wdata : m0.req_wdata;
                r_size  <= w_size;
                r_addr  <= w_addr;
                r_err   <= w_err;
            end
            if (r_state == ACCESS)
                r_rdata <= (w_drive & ~r_we) ? data_read_data : '0;
        end
    end

    // Errored requests never reach the memory bus
    assign w_drive         = (r_state == ACCESS) & ~r_err;
    assign mem_read        = w_drive & ~r_we;
    assign mem_write       = w_drive & r_we;
    assign mem_size        = w_drive ? r_size : 2'b00;
    assign unsigned_load   = w_drive & r_uns;
    assign data_addr       = w_drive ? r_addr : '0;
    assign data_write_data = w_drive ? r_wdata : '0;

    assign w_rsp0       = (r_state == RESP) & ~r_port;
    assign w_rsp1       = (r_state == RESP) & r_port;
    assign m0.rsp_valid = w_rsp0;
    assign m0.rsp_rdata = w_rsp0 ? r_rdata : '0;
    assign m0.rsp_err   = w_rsp0 & r_err;
    assign m1.rsp_valid = w_rsp1;
    assign m1.rsp_rdata = w_rsp1 ? r_rdata : '0;
    assign m1.rsp_err   = w_rsp1 & r_err;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory (byte/half/word, sign/zero-extending loads).
- Port 0 is the core load/store path; port 1 is the debug/DMA path.
- Accepts one request at a time, checks alignment and range, and drives the memory control bus for exactly one cycle.
- Returns registered read data plus an error flag to the requester that won arbitration.

Parameters:
- DMEM_BYTES, 4096: addressable data memory size in bytes; addresses >= DMEM_BYTES are errors.
- FIXED_PRIO, 0: 0 = round-robin; 1 = port 0 always wins a tie.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- m0_req_valid / m1_req_valid  in  1  request present.
- m0_req_ready / m1_req_ready  out  1  request accepted this cycle (valid & ready).
- m0_req_we / m1_req_we  in  1  1 = store, 0 = load.
- m0_req_size / m1_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- m0_req_unsigned / m1_req_unsigned  in  1  zero-extend load.
- m0_req_addr / m1_req_addr  in  32  byte address.
- m0_req_wdata / m1_req_wdata  in  32  store data, low-aligned.
- m0_rsp_valid / m1_rsp_valid  out  1  one-cycle response pulse.
- m0_rsp_rdata / m1_rsp_rdata  out  32  load result; 0 for stores and errors.
- m0_rsp_err / m1_rsp_err  out  1  misaligned, illegal size or out-of-range.
- mem_read, mem_write  out  1  memory strobes.
- mem_size  out  2  to memory.
- unsigned_load  out  1  to memory.
- data_addr  out  32  to memory.
- data_write_data  out  32  to memory.
- data_read_data  in  32  combinational read data from memory.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Reset values: all outputs 0; last_grant = 1, so port 0 wins the first tie.
- Request ready (both ports):
  - reqN_ready is asserted only in IDLE or RESP, and only for the selected port.
  - It is combinational from valid and the arbitration decision.
  - At most one ready is high per cycle.
- Arbitration:
  - Only one port valid: that port is granted.
  - Both valid, FIXED_PRIO=0: the port not equal to last_grant is granted.
  - Both valid, FIXED_PRIO=1: port 0 is granted.
  - last_grant updates on each accept.
- Accept (valid & ready at edge N):
  - Latch we, size, unsigned, addr, wdata, port id and err into registers.
  - err = (size==11) | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0) | (addr >= DMEM_BYTES).
  - Go to ACCESS.
- ACCESS (cycle N+1):
  - If err=0, drive mem_read=~we and mem_write=we, plus size, unsigned, addr and wdata from the latched registers.
  - Store commits at the edge ending this cycle.
  - Capture data_read_data into the rdata register for loads; capture 0 for stores.
  - If err=1, both strobes stay 0 and rdata=0.
  - Go to RESP.
- RESP (cycle N+2):
  - Granted port's rsp_valid=1 with the registered rdata and err. Other port's rsp outputs are 0.
  - A new accept may occur in this same cycle → ACCESS. Otherwise → IDLE.
  - Sustained throughput: one transaction per 2 cycles. Load-to-response latency: 2 cycles after accept.
- Memory bus outside ACCESS: all memory outputs 0 (mem_read=0 keeps memory read data at 0).
- Requester obligation: request fields must be held stable while valid & ~ready. The arbiter never drops a valid request; an unaccepted port is retried the next eligible cycle.
- Reset mid-operation:
  - In ACCESS: the store is not committed if rst is asserted before the edge, and no response is issued.
  - In RESP: the response pulse is cut immediately.
- Errors never touch memory and never block the other port.

Decomposition:
- Shared package (riscv_pkg) additions:
  - mem_size_e enum: MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10.
  - dmem_arb_state_e enum: IDLE, ACCESS, RESP.
  - DMEM_BYTES derived from the existing DMEM_SIZE*4.
- Sub-module: dmem_align_check, purely combinational. Inputs: size, addr. Output: err. Reused later by the LSU.

Test Plan:
- Port 0 SW addr 0x10 data 0xA5A5_1234, then LB addr 0x11 signed → m0 rsp_valid 2 cycles after LB accept, rdata 0x0000_0012, err 0; memory sees mem_write for exactly one cycle.
- Both ports valid continuously with LW, FIXED_PRIO=0 → grants alternate 0,1,0,1; each rsp_valid pulses once per accept; accepts spaced 2 cycles.
- FIXED_PRIO=1 with both valid for 6 transactions → port 1 never readied while port 0 valid; port 1 served when port 0 drops valid.
- SH addr 0x3, LW addr 0x2, size 11, LW addr 0x1000 → each gives rsp_err=1, rdata 0; mem_read and mem_write stay 0 throughout.
- SB 0x7F to addr 0x22, then LBU and LB at 0x22 → 0x0000_007F both; SB 0x80, then LB → 0xFFFF_FF80, LBU → 0x0000_0080.
- Assert rst during ACCESS of a SW to 0x40 holding 0 → all outputs 0 at once, no rsp_valid; a subsequent LW 0x40 returns 0; the first tie after reset goes to port 0.
